uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_receiver_if.sv | 36 +++
 rtl/uart_rx_tickgen.sv | 48 ++++
 rtl/uart_receiver.sv | 173 +++++++++++++++++
 tb/tb_uart_receiver.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, debug view and a clog2 helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Observation bundle so checkers can see exactly where the FSM is within a frame.
    typedef struct packed {
        rx_state_t  state;
        logic [7:0] tcnt;
        logic [2:0] bcnt;
        logic       tick;
    } rx_dbg_t;

    function automatic int clog2(input longint unsigned value);
        int              result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side interface of the UART receiver: holding register, error pulses, debug view.
interface uart_receiver_if;
    import uart_pkg::*;

    // rx_valid is a level: it stays high until a cycle with rx_ack = 1 has been
    // clocked. rx_ack while rx_valid = 0 is ignored. A byte is transferred on each
    // clock edge that ends a cycle with rx_valid = 1 and rx_ack = 1.
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ack;
    logic                      frame_err;
    logic                      overrun;
    logic                      rx_busy;
    rx_dbg_t                   dbg;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ack,
        output frame_err,
        output overrun,
        output rx_busy,
        output dbg
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ack,
        input  frame_err,
        input  overrun,
        input  rx_busy,
        input  dbg
    );

endinterface

// File: rtl/uart_rx_tickgen.sv
// Fractional-accumulator oversampling tick: averages BAUD*OVERSAMPLE ticks per second.
module uart_rx_tickgen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int               ACC_W = clog2(CLK_FREQ) + 1;
    localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD * OVERSAMPLE);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_tickgen: OVERSAMPLE must be an even number >= 4");
    end

    if (BAUD * OVERSAMPLE > CLK_FREQ) begin : g_bad_rate
        $error("uart_rx_tickgen: BAUD*OVERSAMPLE must not exceed CLK_FREQ");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // acc < CLK_FREQ and INC <= CLK_FREQ, so the sum never exceeds ACC_W bits.
    assign sum  = acc + INC;
    assign wrap = (sum >= LIMIT);
    assign tick = wrap && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (restart) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= sum - LIMIT;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with start/stop validation and a valid/ack holding register.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rxd,
    uart_receiver_if.master bus
);

    localparam int                TCNT_W    = clog2(OVERSAMPLE);
    localparam int                BCNT_W    = clog2(UART_DATA_BITS);
    localparam logic [TCNT_W-1:0] TC_HALF   = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TC_LAST   = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(UART_DATA_BITS - 1);

    logic [1:0]                sync;
    logic                      rxs;
    logic                      restart;
    logic                      tick;

    rx_state_t                 state,   state_nx;
    logic [TCNT_W-1:0]         tcnt,    tcnt_nx;
    logic [BCNT_W-1:0]         bcnt,    bcnt_nx;
    logic [UART_DATA_BITS-1:0] shift,   shift_nx;
    logic [UART_DATA_BITS-1:0] data_q,  data_nx;
    logic                      valid_q, valid_nx;
    logic                      ferr_q,  ferr_nx;
    logic                      ovr_q,   ovr_nx;

    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxs = sync[1];

    uart_rx_tickgen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tickgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            bcnt    <= bcnt_nx;
            shift   <= shift_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            ferr_q  <= ferr_nx;
            ovr_q   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        shift_nx = shift;
        data_nx  = data_q;
        valid_nx = valid_q;
        ferr_nx  = 1'b0;
        ovr_nx   = 1'b0;
        restart  = 1'b0;

        if (bus.rx_ack) begin
            valid_nx = 1'b0;
        end

        case (state)
            RX_IDLE: begin
                // Tick phase is re-aligned to the falling start edge.
                if (!rxs) begin
                    restart  = 1'b1;
                    tcnt_nx  = '0;
                    state_nx = RX_START;
                end
            end

            RX_START: begin
                if (tick) begin
                    if (tcnt == TC_HALF) begin
                        tcnt_nx = '0;
                        bcnt_nx = '0;
                        state_nx = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end

            RX_DATA: begin
                if (tick) begin
                    if (tcnt == TC_LAST) begin
                        shift_nx = {rxs, shift[UART_DATA_BITS-1:1]};
                        tcnt_nx  = '0;
                        bcnt_nx  = bcnt + 1'b1;
                        if (bcnt == BCNT_LAST) begin
                            state_nx = RX_STOP;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end

            RX_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be seen in IDLE.
                if (tick) begin
                    if (tcnt == TC_LAST) begin
                        tcnt_nx = '0;
                        if (rxs) begin
                            if (!valid_q || bus.rx_ack) begin
                                data_nx  = shift;
                                valid_nx = 1'b1;
                            end else begin
                                ovr_nx = 1'b1;
                            end
                            state_nx = RX_IDLE;
                        end else begin
                            ferr_nx  = 1'b1;
                            state_nx = RX_BREAK;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end

            RX_BREAK: begin
                if (rxs) begin
                    state_nx = RX_IDLE;
                end
            end

            default: begin
                state_nx = RX_IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.rx_busy   = (state != RX_IDLE);
    assign bus.dbg       = '{state: state, tcnt: 8'(tcnt), bcnt: 3'(bcnt), tick: tick};

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table plus hand-written corner sequences.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CLK_FREQ   = 12000000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 8;
    localparam int BIT_CLKS   = 104;
    localparam int WAIT_MAX   = 3000;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rxd     = 1'b1;
    logic man_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic valid_at_stop_start = 1'b0;
    logic [7:0] exp_q[$];
    vec_t vecs[8];

    uart_receiver_if bus();
    assign bus.rx_ack = man_ack;

    uart_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .bus   (bus.master)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rst_n && bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit; line left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        valid_at_stop_start = bus.rx_valid;
        rxd = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_valid) ok = 1'b1;
        end
    endtask

    // Scoreboard pop: wait for a byte and compare it with the oldest expectation.
    task automatic expect_byte(input string name);
        bit ok;
        logic [7:0] exp;
        wait_valid(ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got rx_valid=0, expected rx_valid=1", name);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got byte 0x%0h, expected none", name, bus.rx_data);
        end else begin
            exp = exp_q.pop_front();
            check(name, 32'(bus.rx_data), 32'(exp));
        end
    endtask

    task automatic ack_and_check(input string name);
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check(name, 32'(bus.rx_valid), 32'd0);
    endtask

    task automatic ack_at_stop_sample(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 4 * WAIT_MAX && !hit; i++) begin
            @(negedge clk);
            if (bus.dbg.state == RX_STOP && bus.dbg.tick && bus.dbg.tcnt == 8'(OVERSAMPLE - 1)) begin
                man_ack = 1'b1;
                @(negedge clk);
                man_ack = 1'b0;
                hit = 1'b1;
            end
        end
    endtask

    initial begin
        int f0;
        int o0;
        bit hit;
        logic [7:0] partial;

        vecs[0] = '{8'h21, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h7E, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h0F, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_data",  32'(bus.rx_data),   32'd0);
        check("rst_valid", 32'(bus.rx_valid),  32'd0);
        check("rst_busy",  32'(bus.rx_busy),   32'd0);
        check("rst_ferr",  32'(bus.frame_err), 32'd0);
        check("rst_ovr",   32'(bus.overrun),   32'd0);
        check("rst_state", 32'(bus.dbg.state), 32'(RX_IDLE));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Vector table: good frames and one frame with a low stop bit
        foreach (vecs[i]) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            check($sformatf("vec%0d_valid_before_stop", i), 32'(valid_at_stop_start), 32'd0);
            if (vecs[i].stop_bit) begin
                expect_byte($sformatf("vec%0d_data", i));
                ack_and_check($sformatf("vec%0d_ack_clear", i));
            end else begin
                repeat (300) @(negedge clk);
                check($sformatf("vec%0d_break_state", i), 32'(bus.dbg.state), 32'(RX_BREAK));
                check($sformatf("vec%0d_break_busy", i), 32'(bus.rx_busy), 32'd1);
                check($sformatf("vec%0d_valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
                rxd = 1'b1;
                repeat (10) @(negedge clk);
                check($sformatf("vec%0d_idle_after_break", i), 32'(bus.dbg.state), 32'(RX_IDLE));
            end
            check($sformatf("vec%0d_ferr_pulses", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr_pulses", i), 32'(ovr_cnt - o0), 32'd0);
            repeat (50) @(negedge clk);
        end

        // Back-to-back frames with concurrent acknowledgement
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'hA3, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    expect_byte($sformatf("loop%0d_data", k));
                    ack_and_check($sformatf("loop%0d_ack_clear", k));
                end
            end
        join
        check("loop_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
        check("loop_ovr_pulses", 32'(ovr_cnt - o0), 32'd0);
        repeat (50) @(negedge clk);

        // False start: short low glitch
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        check("false_start_busy", 32'(bus.dbg.state), 32'(RX_START));
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("false_start_idle",  32'(bus.dbg.state), 32'(RX_IDLE));
        check("false_start_valid", 32'(bus.rx_valid),  32'd0);
        check("false_start_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

        // Overrun: second byte dropped while first is unacknowledged
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        expect_byte("ovr_first");
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_pulse",   32'(ovr_cnt - o0),  32'd1);
        check("ovr_keep",    32'(bus.rx_data),   32'h11);
        check("ovr_valid",   32'(bus.rx_valid),  32'd1);
        ack_and_check("ovr_ack_clear");
        repeat (50) @(negedge clk);

        // Ack in the stop-sample cycle: new byte loads, no overrun
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        expect_byte("same_cycle_first");
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            ack_at_stop_sample(hit);
        join
        check("same_cycle_hit", 32'(hit), 32'd1);
        expect_byte("same_cycle_data");
        check("same_cycle_valid", 32'(bus.rx_valid), 32'd1);
        check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        ack_and_check("same_cycle_ack_clear");
        repeat (50) @(negedge clk);

        // Reset during bit 4 of 0xC3
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        partial = 8'hC3;
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = partial[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("abort_busy_before", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_rst_busy",  32'(bus.rx_busy),  32'd0);
        check("abort_rst_data",  32'(bus.rx_data),  32'd0);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check("abort_no_valid", 32'(bus.rx_valid), 32'd0);
        check("abort_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        expect_byte("abort_next_data");
        ack_and_check("abort_next_ack_clear");

        // Ack while nothing is pending has no effect
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ack_ignored", 32'(bus.rx_valid), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
